// File: rtl/i2c_slave_regmap.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : i2c_slave_regmap                                                |
// | Purpose  : I2C target with register-pointer protocol. 7-bit address match, |
// |            pointer byte, burst write/read with pointer auto-increment,     |
// |            repeated START, master NACK handling. No clock stretching.      |
// | Ports    : clk, resetn (async active-low)                                  |
// |            scl_i, sda_i      : pad inputs (asynchronous)                   |
// |            sda_oe_o          : 1 = pull SDA low                            |
// |            wr_en_o/wr_addr_o/wr_data_o : one-cycle register write          |
// |            rd_addr_o/rd_data_i : register read pointer and returned data   |
// |            busy_o            : START..STOP                                 |
// |            addressed_o       : address ACK..STOP/Sr                        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module i2c_slave_regmap #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50,
    parameter int         REG_ADDR_W = 4,
    parameter int         DATA_W     = 8
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  scl_i,
    input  logic                  sda_i,
    output logic                  sda_oe_o,
    output logic                  wr_en_o,
    output logic [REG_ADDR_W-1:0] wr_addr_o,
    output logic [DATA_W-1:0]     wr_data_o,
    output logic [REG_ADDR_W-1:0] rd_addr_o,
    input  logic [DATA_W-1:0]     rd_data_i,
    output logic                  busy_o,
    output logic                  addressed_o
);

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_ADDR      = 4'd1;
    localparam logic [3:0] S_ADDR_ACK  = 4'd2;
    localparam logic [3:0] S_PTR       = 4'd3;
    localparam logic [3:0] S_PTR_ACK   = 4'd4;
    localparam logic [3:0] S_WR_DATA   = 4'd5;
    localparam logic [3:0] S_WR_ACK    = 4'd6;
    localparam logic [3:0] S_RD_DATA   = 4'd7;
    localparam logic [3:0] S_RD_ACK    = 4'd8;
    localparam logic [3:0] S_WAIT_STOP = 4'd9;

    localparam logic [REG_ADDR_W-1:0] c_PTR_ONE = {{(REG_ADDR_W-1){1'b0}}, 1'b1};

    // Synchroniser (s1, s2) plus one history flop per pad
    logic r_scl_s1, r_scl_s2, r_scl_d;
    logic r_sda_s1, r_sda_s2, r_sda_d;

    logic [3:0]            r_state;
    logic [2:0]            r_bit_cnt;
    logic [6:0]            r_shift;   // 7 bits suffice: the 8th bit is taken live from SDA
    logic [REG_ADDR_W-1:0] r_ptr;
    logic                  r_rw;
    logic                  r_ninth;   // 9th SCL rise seen in an ACK state
    logic                  r_sda_oe;
    logic                  r_wr_en;
    logic [REG_ADDR_W-1:0] r_wr_addr;
    logic [DATA_W-1:0]     r_wr_data;
    logic                  r_busy;
    logic                  r_addressed;

    logic       w_scl_rise, w_scl_fall, w_start, w_stop;
    logic [7:0] w_byte;

    assign w_scl_rise = r_scl_s2 & ~r_scl_d;
    assign w_scl_fall = ~r_scl_s2 & r_scl_d;
    assign w_start    = r_scl_s2 & r_scl_d & r_sda_d & ~r_sda_s2;
    assign w_stop     = r_scl_s2 & r_scl_d & ~r_sda_d & r_sda_s2;
    assign w_byte     = {r_shift, r_sda_s2};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_scl_s1    <= 1'b1;
            r_scl_s2    <= 1'b1;
            r_scl_d     <= 1'b1;
            r_sda_s1    <= 1'b1;
            r_sda_s2    <= 1'b1;
            r_sda_d     <= 1'b1;
            r_state     <= S_IDLE;
            r_bit_cnt   <= 3'd0;
            r_shift     <= 7'd0;
            r_ptr       <= '0;
            r_rw        <= 1'b0;
            r_ninth     <= 1'b0;
            r_sda_oe    <= 1'b0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_busy      <= 1'b0;
            r_addressed <= 1'b0;
        end else begin
            r_scl_s1 <= scl_i;
            r_scl_s2 <= r_scl_s1;
            r_scl_d  <= r_scl_s2;
            r_sda_s1 <= sda_i;
            r_sda_s2 <= r_sda_s1;
            r_sda_d  <= r_sda_s2;
            r_wr_en  <= 1'b0;

            if (w_stop) begin
                r_state     <= S_IDLE;
                r_busy      <= 1'b0;
                r_sda_oe    <= 1'b0;
                r_addressed <= 1'b0;
            end else if (w_start) begin
                // START or repeated START; pointer is deliberately retained
                r_state     <= S_ADDR;
                r_busy      <= 1'b1;
                r_sda_oe    <= 1'b0;
                r_addressed <= 1'b0;
                r_bit_cnt   <= 3'd0;
            end else begin
                case (r_state)
                    S_ADDR: begin
                        if (w_scl_rise) begin
                            r_shift   <= w_byte[6:0];
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) begin
                                // General call (address 0) falls through as mismatch
                                if (w_byte[7:1] == SLAVE_ADDR && w_byte[7:1] != 7'd0) begin
                                    r_state <= S_ADDR_ACK;
                                    r_rw    <= w_byte[0];
                                    r_ninth <= 1'b0;
                                end else begin
                                    r_state <= S_WAIT_STOP;
                                end
                            end
                        end
                    end
                    S_ADDR_ACK: begin
                        if (w_scl_rise) begin
                            r_ninth <= 1'b1;
                        end else if (w_scl_fall) begin
                            if (!r_ninth) begin
                                r_sda_oe    <= 1'b1;
                                r_addressed <= 1'b1;
                            end else if (r_rw) begin
                                r_shift   <= rd_data_i[6:0];
                                r_sda_oe  <= ~rd_data_i[7];
                                r_bit_cnt <= 3'd0;
                                r_state   <= S_RD_DATA;
                            end else begin
                                r_sda_oe  <= 1'b0;
                                r_bit_cnt <= 3'd0;
                                r_state   <= S_PTR;
                            end
                        end
                    end
                    S_PTR: begin
                        if (w_scl_rise) begin
                            r_shift   <= w_byte[6:0];
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) begin
                                r_ptr   <= w_byte[REG_ADDR_W-1:0];
                                r_ninth <= 1'b0;
                                r_state <= S_PTR_ACK;
                            end
                        end
                    end
                    S_WR_DATA: begin
                        if (w_scl_rise) begin
                            r_shift   <= w_byte[6:0];
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) begin
                                r_wr_en   <= 1'b1;
                                r_wr_addr <= r_ptr;
                                r_wr_data <= w_byte;
                                r_ninth   <= 1'b0;
                                r_state   <= S_WR_ACK;
                            end
                        end
                    end
                    S_PTR_ACK, S_WR_ACK: begin
                        if (w_scl_rise) begin
                            r_ninth <= 1'b1;
                        end else if (w_scl_fall) begin
                            if (!r_ninth) begin
                                r_sda_oe <= 1'b1;
                            end else begin
                                r_sda_oe  <= 1'b0;
                                r_bit_cnt <= 3'd0;
                                r_state   <= S_WR_DATA;
                                if (r_state == S_WR_ACK)
                                    r_ptr <= r_ptr + c_PTR_ONE;
                            end
                        end
                    end
                    S_RD_DATA: begin
                        if (w_scl_rise) begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) begin
                                r_ninth <= 1'b0;
                                r_state <= S_RD_ACK;
                            end
                        end else if (w_scl_fall) begin
                            r_sda_oe <= ~r_shift[6];
                            r_shift  <= {r_shift[5:0], 1'b0};
                        end
                    end
                    S_RD_ACK: begin
                        if (w_scl_rise) begin
                            // Every transmitted byte advances the pointer, ACKed or not
                            r_ninth <= 1'b1;
                            r_ptr   <= r_ptr + c_PTR_ONE;
                            if (r_sda_s2)
                                r_state <= S_WAIT_STOP;
                        end else if (w_scl_fall) begin
                            if (!r_ninth) begin
                                r_sda_oe <= 1'b0;
                            end else begin
                                r_shift   <= rd_data_i[6:0];
                                r_sda_oe  <= ~rd_data_i[7];
                                r_bit_cnt <= 3'd0;
                                r_state   <= S_RD_DATA;
                            end
                        end
                    end
                    S_IDLE, S_WAIT_STOP: begin
                        r_sda_oe <= 1'b0;
                    end
                    default: begin
                        r_state  <= S_IDLE;
                        r_sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign sda_oe_o    = r_sda_oe;
    assign wr_en_o     = r_wr_en;
    assign wr_addr_o   = r_wr_addr;
    assign wr_data_o   = r_wr_data;
    assign rd_addr_o   = r_ptr;
    assign busy_o      = r_busy;
    assign addressed_o = r_addressed;

endmodule
`default_nettype wire

// File: tb/tb_i2c_slave_regmap.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_i2c_slave_regmap                                             |
// | Purpose  : Self-checking bench for i2c_slave_regmap: bus master model,     |
// |            constant register bank (bank[i] = 0x40 + i), write/read         |
// |            scoreboards.                                                    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_i2c_slave_regmap;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       scl = 1'b1;
    logic       m_sda = 1'b1;
    logic       sda_line;
    logic       sda_oe, wr_en, busy, addressed;
    logic [3:0] wr_addr, rd_addr;
    logic [7:0] wr_data, rd_data;

    int total = 0;
    int bad = 0;
    int oe_cnt = 0;
    int addr_cnt = 0;
    int obs_idx = 0;

    logic [11:0] obs_wr_q[$];
    logic [11:0] exp_wr_q[$];
    logic [7:0]  exp_rd_q[$];

    assign sda_line = m_sda & ~sda_oe;
    assign rd_data  = 8'h40 + {4'h0, rd_addr};

    i2c_slave_regmap #(.SLAVE_ADDR(7'h50), .REG_ADDR_W(4), .DATA_W(8)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .scl_i      (scl),
        .sda_i      (sda_line),
        .sda_oe_o   (sda_oe),
        .wr_en_o    (wr_en),
        .wr_addr_o  (wr_addr),
        .wr_data_o  (wr_data),
        .rd_addr_o  (rd_addr),
        .rd_data_i  (rd_data),
        .busy_o     (busy),
        .addressed_o(addressed)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_en) obs_wr_q.push_back({wr_addr, wr_data});
        if (sda_oe) oe_cnt++;
        if (addressed) addr_cnt++;
    end

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic q();
        repeat (10) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        q(); m_sda = b; q(); scl = 1'b1; q(); q(); scl = 1'b0;
    endtask

    task automatic recv_bit(output logic b);
        q(); m_sda = 1'b1; q(); scl = 1'b1; q(); b = sda_line; q(); scl = 1'b0;
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; scl = 1'b1; q(); m_sda = 1'b0; q(); scl = 1'b0;
    endtask

    task automatic i2c_rstart();
        q(); m_sda = 1'b1; q(); scl = 1'b1; q(); m_sda = 1'b0; q(); scl = 1'b0;
    endtask

    task automatic i2c_stop();
        q(); m_sda = 1'b0; q(); scl = 1'b1; q(); m_sda = 1'b1; q();
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        recv_bit(b);
        ack = ~b;
    endtask

    task automatic read_byte(output logic [7:0] d, input logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(b);
            d[i] = b;
        end
        send_bit(~ack);
    endtask

    // Data byte sent to a matched target: expect a register write
    task automatic write_data(input logic [3:0] a, input logic [7:0] d, input string tag);
        logic ack;
        exp_wr_q.push_back({a, d});
        write_byte(d, ack);
        check(tag, int'(ack), 1);
    endtask

    task automatic read_check(input logic ack, input string tag);
        logic [7:0] d;
        logic [7:0] e;
        read_byte(d, ack);
        e = exp_rd_q.pop_front();
        check(tag, int'(d), int'(e));
    endtask

    task automatic compare_writes(input string tag);
        logic [11:0] e;
        while (exp_wr_q.size() > 0) begin
            e = exp_wr_q.pop_front();
            if (obs_idx < obs_wr_q.size()) begin
                check(tag, int'(obs_wr_q[obs_idx]), int'(e));
                obs_idx++;
            end else begin
                check({tag, "_missing"}, -1, int'(e));
            end
        end
        check({tag, "_extra"}, obs_wr_q.size() - obs_idx, 0);
    endtask

    initial begin
        logic ack;
        int   oe0, ad0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_sda_oe", int'(sda_oe), 0);
        check("rst_wr_en", int'(wr_en), 0);
        check("rst_wr_addr", int'(wr_addr), 0);
        check("rst_wr_data", int'(wr_data), 0);
        check("rst_rd_addr", int'(rd_addr), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_addressed", int'(addressed), 0);
        resetn = 1'b1;
        q();

        // Write burst to 3,4,5
        i2c_start();
        q();
        check("wb_busy", int'(busy), 1);
        write_byte(8'hA0, ack); check("wb_addr_ack", int'(ack), 1);
        check("wb_addressed", int'(addressed), 1);
        write_byte(8'h03, ack); check("wb_ptr_ack", int'(ack), 1);
        write_data(4'h3, 8'h11, "wb_ack0");
        write_data(4'h4, 8'h22, "wb_ack1");
        write_data(4'h5, 8'h33, "wb_ack2");
        i2c_stop();
        q();
        check("wb_busy_end", int'(busy), 0);
        check("wb_addressed_end", int'(addressed), 0);
        check("wb_ptr", int'(rd_addr), 6);
        compare_writes("wb_wr");

        // Pointer write, Sr, read 3 bytes with wrap
        i2c_start();
        write_byte(8'hA0, ack); check("rd_addr_ack", int'(ack), 1);
        write_byte(8'h0E, ack); check("rd_ptr_ack", int'(ack), 1);
        i2c_rstart();
        write_byte(8'hA1, ack); check("rd_addr2_ack", int'(ack), 1);
        exp_rd_q.push_back(8'h4E);
        exp_rd_q.push_back(8'h4F);
        exp_rd_q.push_back(8'h40);
        read_check(1'b1, "rd_byte0");
        read_check(1'b1, "rd_byte1");
        read_check(1'b0, "rd_byte2");
        i2c_stop();
        q();
        check("rd_ptr_end", int'(rd_addr), 1);
        check("rd_busy_end", int'(busy), 0);
        compare_writes("rd_nowr");

        // Address mismatch and general call
        oe0 = oe_cnt;
        ad0 = addr_cnt;
        i2c_start();
        write_byte(8'hA4, ack); check("mm_addr_nack", int'(ack), 0);
        write_byte(8'h55, ack); check("mm_data_nack", int'(ack), 0);
        check("mm_busy", int'(busy), 1);
        i2c_stop();
        q();
        check("mm_busy_end", int'(busy), 0);
        i2c_start();
        write_byte(8'h00, ack); check("gc_nack", int'(ack), 0);
        i2c_stop();
        q();
        check("mm_oe_never", oe_cnt - oe0, 0);
        check("mm_addressed_never", addr_cnt - ad0, 0);
        compare_writes("mm_nowr");

        // STOP in the middle of a data byte
        i2c_start();
        write_byte(8'hA0, ack);
        write_byte(8'h02, ack);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        i2c_stop();
        q();
        check("pb_busy_end", int'(busy), 0);
        compare_writes("pb_nowr");
        i2c_start();
        write_byte(8'hA0, ack); check("pb2_addr_ack", int'(ack), 1);
        write_byte(8'h02, ack);
        write_data(4'h2, 8'h99, "pb2_ack");
        i2c_stop();
        q();
        compare_writes("pb2_wr");

        // Async reset while driving a read bit (bank[0]=0x40, MSB 0)
        i2c_start();
        write_byte(8'hA0, ack);
        write_byte(8'h00, ack);
        i2c_rstart();
        write_byte(8'hA1, ack);
        repeat (8) @(posedge clk);
        #2;
        check("ar_driving", int'(sda_oe), 1);
        resetn = 1'b0;
        #1;
        check("ar_sda_oe", int'(sda_oe), 0);
        check("ar_busy", int'(busy), 0);
        check("ar_addressed", int'(addressed), 0);
        check("ar_rd_addr", int'(rd_addr), 0);
        check("ar_wr_en", int'(wr_en), 0);
        m_sda = 1'b1;
        scl = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
        q();

        // Transaction after reset: write then read back address
        i2c_start();
        write_byte(8'hA0, ack); check("ar2_addr_ack", int'(ack), 1);
        write_byte(8'h07, ack);
        write_data(4'h7, 8'h5A, "ar2_ack");
        i2c_stop();
        q();
        compare_writes("ar2_wr");
        i2c_start();
        write_byte(8'hA0, ack);
        write_byte(8'h07, ack);
        i2c_rstart();
        write_byte(8'hA1, ack); check("ar3_addr_ack", int'(ack), 1);
        exp_rd_q.push_back(8'h47);
        read_check(1'b0, "ar3_byte");
        i2c_stop();
        q();
        check("ar3_ptr", int'(rd_addr), 8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/i2c_slave_regmap.md
# i2c_slave_regmap

Parametrised I2C target with a register-pointer protocol: 7-bit address match, pointer byte, multi-byte burst writes and reads with pointer auto-increment, repeated-START support and master-NACK handling. Sits between the open-drain pad wrappers and a user register bank, exposing a single-cycle write strobe and a read-address/read-data pair. Successor to the single-byte slave; standard-mode and fast-mode buses, no clock stretching.

## Interface
- SLAVE_ADDR, 7'h50, 7-bit target address matched against the first byte after START/Sr
- REG_ADDR_W, 4, register pointer width; bank holds 2^REG_ADDR_W bytes, pointer wraps modulo that
- DATA_W, 8, fixed at 8 (I2C byte); parameter present for width checks only
- clk  input  1  system clock; all logic on rising edge
- resetn  input  1  asynchronous, active-low reset
- scl_i  input  1  SCL pad input (asynchronous)
- sda_i  input  1  SDA pad input (asynchronous)
- sda_oe_o  output  1  1 = pull SDA low (pad drives 0), 0 = release
- wr_en_o  output  1  one-cycle strobe: wr_addr_o/wr_data_o valid
- wr_addr_o  output  REG_ADDR_W  register address of the write
- wr_data_o  output  8  write data byte
- rd_addr_o  output  REG_ADDR_W  current pointer; user returns data combinationally or registered within 2 clk
- rd_data_i  input  8  read data for rd_addr_o
- busy_o  output  1  high from START detect to STOP detect
- addressed_o  output  1  high from address ACK until STOP/Sr

## Operation
- scl_i, sda_i each pass through 2-flop synchroniser plus one history flop; edges and START/STOP derived from synchronised values only.
- START: SDA 1->0 while SCL high; STOP: SDA 0->1 while SCL high. Both recognised in every state and take priority over bit handling; Sr = START while busy_o high.
- Bits sampled on detected SCL rising edge, MSB first. SDA drive (ACK or data) changes only on detected SCL falling edge.
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP.
- IDLE -START-> ADDR. ADDR after 8 bits: address mismatch -> WAIT_STOP (no ACK, SDA released); match -> ADDR_ACK, sda_oe_o=1 for the 9th clock.
- ADDR_ACK, R/W=0 -> PTR; R/W=1 -> RD_DATA (loads rd_data_i into shift register at the falling edge ending ACK).
- PTR: 8th bit loads pointer[REG_ADDR_W-1:0] (upper bits ignored) -> PTR_ACK (ACK) -> WR_DATA.
- WR_DATA: on 8th bit rising edge assert wr_en_o one clk with wr_addr_o=pointer, wr_data_o=byte -> WR_ACK (ACK); pointer increments at the falling edge ending ACK -> WR_DATA.
- RD_DATA: drive shift register MSB on each falling edge (sda_oe_o = ~bit); after 8th bit release SDA -> RD_ACK. Master ACK (SDA=0 at 9th rising edge): pointer+1, reload from rd_data_i at following falling edge -> RD_DATA. Master NACK -> WAIT_STOP, SDA released.
- WAIT_STOP: ignore bits; leave only on STOP (-> IDLE) or Sr (-> ADDR).
- STOP in any state -> IDLE, sda_oe_o=0, addressed_o=0. Sr in any state -> ADDR, pointer retained (enables write-pointer-then-read).
- Pointer wraps 2^REG_ADDR_W-1 -> 0 in both directions of traffic. Pointer not reset by STOP; reset only by resetn.
- General-call (address 0) not supported: treated as mismatch.

## Timing
- Reset (async assert, sync release): state IDLE, sda_oe_o=0, wr_en_o=0, wr_addr_o=0, wr_data_o=0, rd_addr_o=0, busy_o=0, addressed_o=0, synchroniser flops =1.
- Pad-to-event latency 3 clk (2 sync + 1 edge detect); requires f_clk >= 20 x f_SCL.
- sda_oe_o changes 1 clk after detected SCL falling edge (>= 4 clk after pad edge, satisfies tHD;DAT > 0).
- wr_en_o asserted 1 clk after detected 8th rising edge; exactly 1 clk wide; at most one per byte.
- rd_data_i sampled 2 clk after rd_addr_o update.
- Reset mid-transfer releases SDA immediately (asynchronous).

## Test plan
- Write burst: S 0xA0 ACK, 0x03, 0x11, 0x22, 0x33, P -> three ACKs after address; wr_en_o pulses at addr 3,4,5 with 0x11,0x22,0x33; pointer=6.
- Read with Sr: S 0xA0, 0x0E, Sr 0xA1, read 3 bytes (ACK, ACK, NACK), P; bank[i]=i+0x40 -> SDA returns 0x4E, 0x4F, 0x40 (wrap); rd_addr_o ends at 1.
- Address mismatch: S 0xA4, 0x55, P -> SDA never driven, no wr_en_o, addressed_o stays 0, busy_o high S..P.
- STOP mid-byte: S 0xA0, 0x02, 4 bits of data, P -> no wr_en_o for partial byte; state IDLE; next write S 0xA0 0x02 0x99 P writes 0x99 at 2.
- Async reset during RD_DATA with sda_oe_o=1 -> sda_oe_o=0 same cycle, all outputs at reset values, subsequent transaction correct.
